cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Sequential controller that refills one 4-word (8-byte) cache block from a pipelined main memory after a cache miss. It issues four word reads, counts returning words, and drives the 2-bit word index and write enable that the data-array 2-to-4 word decoder consumes. It also raises the tag-array write on the final word. It sits between the cache hit/miss logic and the data/tag arrays in both the I-cache and the D-cache.

## Interface
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory word width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_detected  in  1  miss request from hit logic; sampled only in IDLE.
- miss_addr  in  ADDR_W  byte address of the missing access.
- memory_data_valid  in  1  returned word valid this cycle.
- memory_data  in  DATA_W  returned word.
- fsm_busy  out  1  fill in progress; stalls pipeline.
- mem_rd_en  out  1  read request to memory this cycle.
- memory_address  out  ADDR_W  read request address.
- word_sel  out  2  word index in block; feeds decoder A.
- word_wr_en  out  1  data-array write strobe; feeds decoder En.
- fill_data  out  DATA_W  data to write; equals memory_data.
- write_tag_array  out  1  tag/valid write strobe, final word only.
- fill_done  out  1  one-cycle pulse coincident with write_tag_array.

## Operation
- States: IDLE, FILL (1 state bit).
- Registers: state, base_addr[ADDR_W-1:3], start_word[1:0], req_cnt[2:0] (0..4), rx_cnt[1:0].
- IDLE and miss_detected: latch base_addr = miss_addr[ADDR_W-1:3] and start_word = miss_addr[2:1]. Clear req_cnt and rx_cnt. Go to FILL.
- IDLE without miss: hold all state. memory_data_valid is ignored.
- FILL, requests: mem_rd_en = (req_cnt < 4). Request word index = req_cnt[1:0], or the rotated index under the macro. memory_address = {base_addr, index, 1'b0}. req_cnt increments each cycle mem_rd_en is high.
- FILL, returns: word_wr_en = memory_data_valid. word_sel = rx_cnt, or the rotated index under the macro. rx_cnt increments, wrapping mod 4, on each valid.
- Last word: a valid with rx_cnt==3 asserts write_tag_array and fill_done, and the FSM goes to IDLE.
- Requests and returns are counted independently. A return may coincide with a request, e.g. with memory latency 1.
- Memory ordering: returns are in request order, and memory never returns more than 4 words per fill.
- miss_detected during FILL is ignored; the hit logic re-presents the miss after fsm_busy drops.
- fsm_busy = (state==FILL).
- All outputs except fill_data are 0 in IDLE.
- Reset, including mid-fill: state=IDLE; all counters and latched fields are 0; all outputs are 0 immediately (asynchronous). The partially written block stays invalid because the tag is never written.

## Timing
- Miss sampled at edge N:
  - FILL from cycle N+1.
  - mem_rd_en high in cycles N+1..N+4, with 4 consecutive addresses.
- Memory latency L (L≥1): word i returns in cycle N+1+i+L.
- word_wr_en, word_sel, fill_data, write_tag_array and fill_done are combinational from memory_data_valid in the same cycle. There is no extra latency.
- fsm_busy falls the cycle after the last valid. A new miss can therefore be accepted at the earliest edge after that.
- Minimum fill duration: 4+L cycles of fsm_busy.

## Configuration
- CACHE_FILL_CRITICAL_FIRST_EN defined:
  - Requests start at start_word and wrap: index = start_word + req_cnt[1:0], mod 4.
  - word_sel = start_word + rx_cnt, mod 4.
  - Termination is still on the 4th returned word.
- Undefined: start_word is forced to 0; requests and word_sel run 0,1,2,3.

## Test plan
- Reset, then idle with memory_data_valid pulsed → all outputs 0, no state change.
- miss_addr=0x1236, L=4, macro off:
  - addresses 0x1230, 0x1232, 0x1234, 0x1236 in cycles N+1..N+4;
  - word_sel 0,1,2,3 with word_wr_en in N+5..N+8;
  - write_tag_array and fill_done high only in N+8;
  - fsm_busy low from N+9.
- Same stimulus with CACHE_FILL_CRITICAL_FIRST_EN → addresses 0x1236, 0x1230, 0x1232, 0x1234; word_sel 3,0,1,2; tag write on the word_sel=2 cycle.
- L=1, data 0xA000+i → each return overlaps the next request; fill_data sequence A000..A003; busy for 5 cycles.
- miss_detected held high throughout a fill → no restart; a second fill starts at the edge after fsm_busy falls.
- rst_n low after 2 returned words:
  - outputs 0 immediately, no tag write;
  - the next miss performs a full 4-word fill from word 0 (macro off).

Source files
------------

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Refills one 4-word (8-byte) cache block from a pipelined main memory after a
// miss. It issues four consecutive word reads. It counts the returning words
// independently of the requests, and for each return it drives the data-array
// word index and write strobe. The tag/valid write is raised on the fourth
// returned word, together with a one-cycle fill_done pulse.
//
// Optional feature macro: CACHE_FILL_CRITICAL_FIRST_EN
//   defined   : requests and word_sel start at the missing word and wrap mod 4
//   undefined : requests and word_sel always run 0,1,2,3
//
// Ports
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   miss_detected     in   miss request, only looked at while idle
//   miss_addr         in   [ADDR_W] byte address of the missing access
//   memory_data_valid in   returned word valid this cycle
//   memory_data       in   [DATA_W] returned word
//   fsm_busy          out  fill in progress (pipeline stall)
//   mem_rd_en         out  read request to memory this cycle
//   memory_address    out  [ADDR_W] read request byte address
//   word_sel          out  [2] word index in block (decoder A)
//   word_wr_en        out  data-array write strobe (decoder En)
//   fill_data         out  [DATA_W] data to write, straight from memory_data
//   write_tag_array   out  tag/valid write strobe, final word only
//   fill_done         out  one-cycle pulse with write_tag_array
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic [1:0]        word_sel,
  output logic              word_wr_en,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array,
  output logic              fill_done
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-4:0] base_addr;
  logic [1:0]        start_word;
  logic [2:0]        req_cnt;
  logic [1:0]        rx_cnt;
  logic [1:0]        req_idx;
  logic [1:0]        rx_idx;
  logic              unused_miss_bits;

  // Byte offset bit is never needed; the word offset only matters when the
  // fill starts at the critical word.
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  assign unused_miss_bits = miss_addr[0];
`else
  assign unused_miss_bits = ^miss_addr[2:0];
`endif

  // Returned data goes straight to the data array with no added latency.
  assign fill_data = memory_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Latched miss fields and the request/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr  <= '0;
      start_word <= 2'd0;
      req_cnt    <= 3'd0;
      rx_cnt     <= 2'd0;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        base_addr  <= miss_addr[ADDR_W-1:3];
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        start_word <= miss_addr[2:1];
`else
        start_word <= 2'd0;
`endif
        req_cnt    <= 3'd0;
        rx_cnt     <= 2'd0;
      end
    end else begin
      if (mem_rd_en) begin
        req_cnt <= req_cnt + 3'd1;
      end
      if (memory_data_valid) begin
        rx_cnt <= rx_cnt + 2'd1;
      end
    end
  end

  // Next state and outputs. Requests and returns are decoded independently
  // so a return can overlap an outstanding request (latency 1 memory).
  always_comb begin
    state_d         = state;
    fsm_busy        = 1'b0;
    mem_rd_en       = 1'b0;
    memory_address  = '0;
    word_sel        = 2'd0;
    word_wr_en      = 1'b0;
    write_tag_array = 1'b0;
    fill_done       = 1'b0;
    // start_word is zero without the critical-first feature, so the same
    // mod-4 sum serves both builds.
    req_idx         = req_cnt[1:0] + start_word;
    rx_idx          = rx_cnt + start_word;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy   = 1'b1;
        mem_rd_en  = ~req_cnt[2];
        if (mem_rd_en) begin
          memory_address = {base_addr, req_idx, 1'b0};
        end
        word_sel   = rx_idx;
        word_wr_en = memory_data_valid;
        // Termination counts returns, not indices, so it is the 4th word
        // whatever the starting word was.
        if (memory_data_valid && (rx_cnt == 2'd3)) begin
          write_tag_array = 1'b1;
          fill_done       = 1'b1;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_addr;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic [1:0]  word_sel;
  logic        word_wr_en;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic        fill_done;

  int checks;
  int errors;

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_addr         (miss_addr),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .word_sel          (word_sel),
    .word_wr_en        (word_wr_en),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every output except fill_data must read zero: in IDLE and under reset.
  task automatic check_all_zero(input string tag);
    checks++;
    if ({fsm_busy, mem_rd_en, memory_address, word_sel, word_wr_en,
         write_tag_array, fill_done} !== 23'd0) begin
      errors++;
      $display("FAIL %s outputs busy=%b rd=%b addr=%h sel=%0d we=%b tag=%b done=%b, expected all 0",
               tag, fsm_busy, mem_rd_en, memory_address, word_sel, word_wr_en,
               write_tag_array, fill_done);
    end
  endtask

  // One complete fill with a fixed-latency memory. Cycle c counts from the
  // edge that samples the miss (c=1 is the first FILL cycle). Word w returns
  // in cycle c = 1+w+lat. Returns with the bench in the first IDLE cycle
  // after the fill, before the next edge.
  task automatic do_fill(input logic [15:0] addr, input int lat,
                         input logic [15:0] dbase,
                         input logic [0:3][15:0] ea,
                         input logic [0:3][1:0] es, input bit hold);
    miss_addr     = addr;
    miss_detected = 1'b1;
    for (int c = 1; c <= 5 + lat; c++) begin
      int w;
      bit v;
      @(posedge clk);
      #1;
      if (c == 1) miss_detected = hold;
      w = c - 1 - lat;
      v = (w >= 0) && (w <= 3);
      memory_data_valid = v;
      memory_data       = dbase + 16'(w);
      #1;
      if (c == 5 + lat) begin
        check_all_zero($sformatf("idle_after_fill_%h", addr));
      end else begin
        checks++;
        if (fsm_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_%h c=%0d got %b exp 1", addr, c, fsm_busy);
        end
        checks++;
        if (mem_rd_en !== (c <= 4)) begin
          errors++;
          $display("FAIL rd_en_%h c=%0d got %b exp %b", addr, c, mem_rd_en, (c <= 4));
        end
        if (c <= 4) begin
          checks++;
          if (memory_address !== ea[c-1]) begin
            errors++;
            $display("FAIL addr_%h c=%0d got %h exp %h", addr, c, memory_address, ea[c-1]);
          end
        end
        checks++;
        if (word_wr_en !== v) begin
          errors++;
          $display("FAIL wr_en_%h c=%0d got %b exp %b", addr, c, word_wr_en, v);
        end
        checks++;
        if ({write_tag_array, fill_done} !== {2{v && (w == 3)}}) begin
          errors++;
          $display("FAIL tag_done_%h c=%0d got %b%b exp %b", addr, c,
                   write_tag_array, fill_done, v && (w == 3));
        end
        if (v) begin
          checks++;
          if (word_sel !== es[w]) begin
            errors++;
            $display("FAIL word_sel_%h c=%0d got %0d exp %0d", addr, c, word_sel, es[w]);
          end
          checks++;
          if (fill_data !== dbase + 16'(w)) begin
            errors++;
            $display("FAIL fill_data_%h c=%0d got %h exp %h", addr, c, fill_data, dbase + 16'(w));
          end
        end
      end
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_all_zero("after_reset_release");
  endtask

  task automatic test_idle_valid;
    @(posedge clk);
    #1;
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    #1;
    check_all_zero("idle_valid");
    checks++;
    if (fill_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL idle_fill_data got %h exp BEEF", fill_data);
    end
    @(posedge clk);
    #1;
    memory_data_valid = 1'b0;
    #1;
    check_all_zero("idle_no_state_change");
  endtask

  task automatic test_fill_l4;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    do_fill(16'h1236, 4, 16'h5000,
            {16'h1236, 16'h1230, 16'h1232, 16'h1234}, {2'd3, 2'd0, 2'd1, 2'd2}, 1'b0);
`else
    do_fill(16'h1236, 4, 16'h5000,
            {16'h1230, 16'h1232, 16'h1234, 16'h1236}, {2'd0, 2'd1, 2'd2, 2'd3}, 1'b0);
`endif
  endtask

  task automatic test_fill_l1;
    do_fill(16'h0AB8, 1, 16'hA000,
            {16'h0AB8, 16'h0ABA, 16'h0ABC, 16'h0ABE}, {2'd0, 2'd1, 2'd2, 2'd3}, 1'b0);
  endtask

  // Miss held high for the whole fill: no restart, and the second fill
  // begins at the edge right after fsm_busy falls.
  task automatic test_back_to_back;
    do_fill(16'h3334, 2, 16'h1100,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            {16'h3334, 16'h3336, 16'h3330, 16'h3332}, {2'd2, 2'd3, 2'd0, 2'd1},
`else
            {16'h3330, 16'h3332, 16'h3334, 16'h3336}, {2'd0, 2'd1, 2'd2, 2'd3},
`endif
            1'b1);
    do_fill(16'h5672, 2, 16'h2200,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            {16'h5672, 16'h5674, 16'h5676, 16'h5670}, {2'd1, 2'd2, 2'd3, 2'd0},
`else
            {16'h5670, 16'h5672, 16'h5674, 16'h5676}, {2'd0, 2'd1, 2'd2, 2'd3},
`endif
            1'b0);
  endtask

  task automatic test_reset_mid_fill;
    miss_addr     = 16'h7774;
    miss_detected = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      memory_data_valid = (c >= 2);
      memory_data       = 16'hC000 + 16'(c);
    end
    // Third word is on the bus; pull reset mid-cycle.
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_fill");
    #1;
    memory_data_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_all_zero("after_mid_fill_release");
    do_fill(16'h4560, 3, 16'hD000,
            {16'h4560, 16'h4562, 16'h4564, 16'h4566}, {2'd0, 2'd1, 2'd2, 2'd3}, 1'b0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_addr         = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;

    test_reset;
    test_idle_valid;
    test_fill_l4;
    test_fill_l1;
    test_back_to_back;
    test_reset_mid_fill;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
